// File: rtl/adder.sv
// Registered WIDTH-bit adder with unsigned carry-out and signed overflow.
// One clock of latency, asynchronous active-low clear of all outputs.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0] sum;
    logic           sign_a;
    logic           sign_b;
    logic           sign_s;
    logic           ovf_next;

    assign sum    = {1'b0, in1} + {1'b0, in2};
    assign sign_a = in1[WIDTH-1];
    assign sign_b = in2[WIDTH-1];
    assign sign_s = sum[WIDTH-1];

    // Overflow only when like-signed operands produce an opposite-signed sum.
    assign ovf_next = (sign_a == sign_b) && (sign_s != sign_a);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            out  <= sum[WIDTH-1:0];
            cout <= sum[WIDTH];
            ovf  <= ovf_next;
        end
    end

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for the registered adder: expected results are queued
// when operands are driven and compared after the following rising edge.
module tb_adder;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;

    exp_t sb[$];
    int   checks;
    int   errors;

    adder #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in1  (in1),
        .in2  (in2),
        .out  (out),
        .cout (cout),
        .ovf  (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Reference model built on wide integer arithmetic, not bit tricks.
    function automatic exp_t model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        exp_t            e;
        longint unsigned u;
        longint          s;
        u = longint'(a) + longint'(b);
        s = longint'($signed(a)) + longint'($signed(b));
        e.out  = u[WIDTH-1:0];
        e.cout = (u >= 64'h1_0000_0000);
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return e;
    endfunction

    task automatic apply(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        in1 = a;
        in2 = b;
        sb.push_back(model(a, b));
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        in1 = 32'h1234_5678;
        in2 = 32'h8765_4321;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out=%h cout=%b ovf=%b want 0/0/0", out, cout, ovf);
        end
        repeat (3) begin
            @(posedge clk);
            in1 = $urandom;
            in2 = $urandom;
            #1;
            checks++;
            if (out !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: out=%h cout=%b ovf=%b want 0/0/0", out, cout, ovf);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors(input string name,
                                input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b);
        exp_t e;
        apply(a, b);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            if (out !== e.out || cout !== e.cout || ovf !== e.ovf) begin
                errors++;
                $display("FAIL %s: out=%h cout=%b ovf=%b want %h/%b/%b",
                         name, out, cout, ovf, e.out, e.cout, e.ovf);
            end
        end
    endtask

    task automatic test_fixed();
        test_vectors("zero", 32'd0, 32'd0);
        test_vectors("basic_631", 32'h631, 32'd341);
        checks++;
        if (out !== 32'd1926) begin
            errors++;
            $display("FAIL basic_1926: out=%0d want 1926", out);
        end
        test_vectors("basic_octal", 32'o1461, 32'd0);
        checks++;
        if (out !== 32'd817 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_817: out=%0d cout=%b ovf=%b want 817/0/0", out, cout, ovf);
        end
        test_vectors("uwrap", 32'hFFFF_FFFF, 32'd1);
        checks++;
        if (out !== 32'd0 || cout !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL uwrap_const: out=%h cout=%b ovf=%b want 0/1/0", out, cout, ovf);
        end
        test_vectors("sovf_pos", 32'h7FFF_FFFF, 32'd1);
        checks++;
        if (out !== 32'h8000_0000 || cout !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL sovf_pos_const: out=%h cout=%b ovf=%b want 80000000/0/1",
                     out, cout, ovf);
        end
        test_vectors("sovf_neg", 32'h8000_0000, 32'h8000_0000);
        checks++;
        if (out !== 32'd0 || cout !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL sovf_neg_const: out=%h cout=%b ovf=%b want 0/1/1", out, cout, ovf);
        end
        test_vectors("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        test_vectors("neg_plus_pos", 32'h8000_0000, 32'h7FFF_FFFF);
        test_vectors("neg_no_ovf", 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    endtask

    task automatic test_hold();
        logic [WIDTH-1:0] held;
        test_vectors("hold_load", 32'd10, 32'd20);
        held = out;
        #2;
        in1 = 32'hDEAD_BEEF;
        in2 = 32'h0BAD_F00D;
        #1;
        checks++;
        if (out !== 32'd30 || held !== 32'd30) begin
            errors++;
            $display("FAIL hold: out=%0d want 30", out);
        end
    endtask

    task automatic test_async_reset();
        test_vectors("pre_reset", 32'h631, 32'd341);
        checks++;
        if (out !== 32'd1926) begin
            errors++;
            $display("FAIL pre_reset_val: out=%0d want 1926", out);
        end
        apply(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (out !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL midstream_reset: out=%h cout=%b ovf=%b want 0/0/0", out, cout, ovf);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_low_hold: out=%h cout=%b ovf=%b want 0/0/0", out, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_vectors("post_release", 32'd5, 32'd7);
        checks++;
        if (out !== 32'd12) begin
            errors++;
            $display("FAIL post_release_val: out=%0d want 12", out);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   bad;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            apply($urandom, (i % 4 == 0) ? 32'h8000_0000 : $urandom);
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL stream[%0d]: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (out !== e.out || cout !== e.cout || ovf !== e.ovf) begin
                    errors++;
                    bad++;
                    if (bad <= 5)
                        $display("FAIL stream[%0d]: out=%h cout=%b ovf=%b want %h/%b/%b",
                                 i, out, cout, ovf, e.out, e.cout, e.ovf);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        in1 = '0;
        in2 = '0;
        test_reset();
        test_fixed();
        test_hold();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
